// File: rtl/exe_alu_pkg.sv
// Shared widths, ALU op codes and small helpers for the execute-stage ALU with forwarding.
package exe_alu_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int CTRL_W  = 6;
    localparam int SHAMT_W = 5;

    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_SUB   = 6'h01;
    localparam logic [5:0] OP_AND   = 6'h02;
    localparam logic [5:0] OP_OR    = 6'h03;
    localparam logic [5:0] OP_XOR   = 6'h04;
    localparam logic [5:0] OP_NOR   = 6'h05;
    localparam logic [5:0] OP_SLT   = 6'h06;
    localparam logic [5:0] OP_SLTU  = 6'h07;
    localparam logic [5:0] OP_SLL   = 6'h08;
    localparam logic [5:0] OP_SRL   = 6'h09;
    localparam logic [5:0] OP_SRA   = 6'h0A;
    localparam logic [5:0] OP_SLLV  = 6'h0B;
    localparam logic [5:0] OP_SRLV  = 6'h0C;
    localparam logic [5:0] OP_SRAV  = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0E;
    localparam logic [5:0] OP_MULT  = 6'h0F;
    localparam logic [5:0] OP_MULTU = 6'h10;
    localparam logic [5:0] OP_DIV   = 6'h11;
    localparam logic [5:0] OP_DIVU  = 6'h12;
    localparam logic [5:0] OP_MFHI  = 6'h13;
    localparam logic [5:0] OP_MFLO  = 6'h14;
    localparam logic [5:0] OP_MTHI  = 6'h15;
    localparam logic [5:0] OP_MTLO  = 6'h16;
    localparam logic [5:0] OP_PASSB = 6'h17;

    // A result is forwardable only when it writes a register and is not a memory op.
    function automatic logic fwd_valid(input logic reg_write,
                                       input logic mem_read,
                                       input logic mem_write);
        return reg_write && !(mem_read || mem_write);
    endfunction

endpackage

// File: rtl/exe_alu_fwd_fwd_sel.sv
// Two-priority operand forward selector: own stage output first, then MEM bypass,
// else the register-file value. Register 0 is never forwarded.
module fwd_sel
    import exe_alu_pkg::*;
(
    input  logic [REG_W-1:0]  rd_reg,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              own_valid,
    input  logic [REG_W-1:0]  own_reg,
    input  logic [DATA_W-1:0] own_data,
    input  logic              byp_valid,
    input  logic [REG_W-1:0]  byp_reg,
    input  logic [DATA_W-1:0] byp_data,
    output logic [DATA_W-1:0] sel_data
);

    // Priority mux over the forwarding sources.
    always_comb begin
        sel_data = rd_data;
        if (rd_reg == 5'd0) begin
            sel_data = rd_data;
        end else if (own_valid && (own_reg == rd_reg)) begin
            sel_data = own_data;
        end else if (byp_valid && (byp_reg == rd_reg)) begin
            sel_data = byp_data;
        end else begin
            sel_data = rd_data;
        end
    end

endmodule

// File: rtl/exe_alu_fwd.sv
// MIPS-style execute stage: operand forwarding, 32-bit ALU, HI/LO, registered MEM outputs.
// Forwarding and the async bypass outputs are built only when FORWARDING_EN is defined.
module exe_alu_fwd
    import exe_alu_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic [REG_W-1:0]   RegisterA1_IN,
    input  logic [DATA_W-1:0]  OperandA1_IN,
    input  logic [REG_W-1:0]   RegisterB1_IN,
    input  logic [DATA_W-1:0]  OperandB1_IN,
    input  logic [REG_W-1:0]   WriteRegister1_IN,
    input  logic [DATA_W-1:0]  MemWriteData1_IN,
    input  logic               RegWrite1_IN,
    input  logic               MemRead1_IN,
    input  logic               MemWrite1_IN,
    input  logic [CTRL_W-1:0]  ALU_Control1_IN,
    input  logic [SHAMT_W-1:0] ShiftAmount1_IN,
    input  logic [REG_W-1:0]   BypassReg1_MEMEXE,
    input  logic [DATA_W-1:0]  BypassData1_MEMEXE,
    input  logic               BypassValid1_MEMEXE,
    output logic [DATA_W-1:0]  ALU_result1_OUT,
    output logic [REG_W-1:0]   WriteRegister1_OUT,
    output logic [DATA_W-1:0]  MemWriteData1_OUT,
    output logic               RegWrite1_OUT,
    output logic               MemRead1_OUT,
    output logic               MemWrite1_OUT,
    output logic [CTRL_W-1:0]  ALU_Control1_OUT,
    output logic [DATA_W-1:0]  ALU_result_async1,
    output logic               ALU_result_async_valid1
);

    logic [DATA_W-1:0]   a_s;
    logic [DATA_W-1:0]   b_s;
    logic [DATA_W-1:0]   st_data_s;
    logic [DATA_W-1:0]   res_s;
    logic [DATA_W-1:0]   hi_nxt_s;
    logic [DATA_W-1:0]   lo_nxt_s;
    logic [2*DATA_W-1:0] prod_s;
    logic [DATA_W-1:0]   hi_r;
    logic [DATA_W-1:0]   lo_r;

`ifdef FORWARDING_EN
    logic own_valid_s;
    assign own_valid_s = fwd_valid(RegWrite1_OUT, MemRead1_OUT, MemWrite1_OUT);

    fwd_sel u_fwd_a (
        .rd_reg    (RegisterA1_IN),
        .rd_data   (OperandA1_IN),
        .own_valid (own_valid_s),
        .own_reg   (WriteRegister1_OUT),
        .own_data  (ALU_result1_OUT),
        .byp_valid (BypassValid1_MEMEXE),
        .byp_reg   (BypassReg1_MEMEXE),
        .byp_data  (BypassData1_MEMEXE),
        .sel_data  (a_s)
    );

    fwd_sel u_fwd_b (
        .rd_reg    (RegisterB1_IN),
        .rd_data   (OperandB1_IN),
        .own_valid (own_valid_s),
        .own_reg   (WriteRegister1_OUT),
        .own_data  (ALU_result1_OUT),
        .byp_valid (BypassValid1_MEMEXE),
        .byp_reg   (BypassReg1_MEMEXE),
        .byp_data  (BypassData1_MEMEXE),
        .sel_data  (b_s)
    );

    // Store data is sourced from the destination index field.
    fwd_sel u_fwd_st (
        .rd_reg    (WriteRegister1_IN),
        .rd_data   (MemWriteData1_IN),
        .own_valid (own_valid_s),
        .own_reg   (WriteRegister1_OUT),
        .own_data  (ALU_result1_OUT),
        .byp_valid (BypassValid1_MEMEXE),
        .byp_reg   (BypassReg1_MEMEXE),
        .byp_data  (BypassData1_MEMEXE),
        .sel_data  (st_data_s)
    );

    assign ALU_result_async1       = res_s;
    assign ALU_result_async_valid1 = fwd_valid(RegWrite1_IN, MemRead1_IN, MemWrite1_IN);
`else
    logic unused_s;
    assign unused_s = ^{RegisterA1_IN, RegisterB1_IN, BypassReg1_MEMEXE,
                        BypassData1_MEMEXE, BypassValid1_MEMEXE};

    assign a_s                     = OperandA1_IN;
    assign b_s                     = OperandB1_IN;
    assign st_data_s               = MemWriteData1_IN;
    assign ALU_result_async1       = 32'd0;
    assign ALU_result_async_valid1 = 1'b0;
`endif

    // ALU datapath and next HI/LO values.
    always_comb begin
        res_s    = 32'd0;
        hi_nxt_s = hi_r;
        lo_nxt_s = lo_r;
        prod_s   = 64'd0;
        case (ALU_Control1_IN)
            OP_ADD:   res_s = a_s + b_s;
            OP_SUB:   res_s = a_s - b_s;
            OP_AND:   res_s = a_s & b_s;
            OP_OR:    res_s = a_s | b_s;
            OP_XOR:   res_s = a_s ^ b_s;
            OP_NOR:   res_s = ~(a_s | b_s);
            OP_SLT:   res_s = ($signed(a_s) < $signed(b_s)) ? 32'd1 : 32'd0;
            OP_SLTU:  res_s = (a_s < b_s) ? 32'd1 : 32'd0;
            OP_SLL:   res_s = b_s << ShiftAmount1_IN;
            OP_SRL:   res_s = b_s >> ShiftAmount1_IN;
            OP_SRA:   res_s = $signed(b_s) >>> ShiftAmount1_IN;
            OP_SLLV:  res_s = b_s << a_s[4:0];
            OP_SRLV:  res_s = b_s >> a_s[4:0];
            OP_SRAV:  res_s = $signed(b_s) >>> a_s[4:0];
            OP_LUI:   res_s = {b_s[15:0], 16'h0000};
            OP_PASSB: res_s = b_s;
            OP_MULT: begin
                prod_s   = {{32{a_s[31]}}, a_s} * {{32{b_s[31]}}, b_s};
                hi_nxt_s = prod_s[63:32];
                lo_nxt_s = prod_s[31:0];
            end
            OP_MULTU: begin
                prod_s   = {32'd0, a_s} * {32'd0, b_s};
                hi_nxt_s = prod_s[63:32];
                lo_nxt_s = prod_s[31:0];
            end
            // Division by zero leaves HI/LO untouched.
            OP_DIV: begin
                if (b_s != 32'd0) begin
                    lo_nxt_s = $signed(a_s) / $signed(b_s);
                    hi_nxt_s = $signed(a_s) % $signed(b_s);
                end else begin
                    lo_nxt_s = lo_r;
                    hi_nxt_s = hi_r;
                end
            end
            OP_DIVU: begin
                if (b_s != 32'd0) begin
                    lo_nxt_s = a_s / b_s;
                    hi_nxt_s = a_s % b_s;
                end else begin
                    lo_nxt_s = lo_r;
                    hi_nxt_s = hi_r;
                end
            end
            OP_MFHI:  res_s    = hi_r;
            OP_MFLO:  res_s    = lo_r;
            OP_MTHI:  hi_nxt_s = a_s;
            OP_MTLO:  lo_nxt_s = a_s;
            default:  res_s    = 32'd0;
        endcase
    end

    // Pipeline registers toward MEM plus HI/LO state.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ALU_result1_OUT    <= 32'd0;
            WriteRegister1_OUT <= 5'd0;
            MemWriteData1_OUT  <= 32'd0;
            RegWrite1_OUT      <= 1'b0;
            MemRead1_OUT       <= 1'b0;
            MemWrite1_OUT      <= 1'b0;
            ALU_Control1_OUT   <= 6'd0;
            hi_r               <= 32'd0;
            lo_r               <= 32'd0;
        end else begin
            ALU_result1_OUT    <= res_s;
            WriteRegister1_OUT <= WriteRegister1_IN;
            MemWriteData1_OUT  <= st_data_s;
            RegWrite1_OUT      <= RegWrite1_IN;
            MemRead1_OUT       <= MemRead1_IN;
            MemWrite1_OUT      <= MemWrite1_IN;
            ALU_Control1_OUT   <= ALU_Control1_IN;
            hi_r               <= hi_nxt_s;
            lo_r               <= lo_nxt_s;
        end
    end

endmodule

// File: tb/tb_exe_alu_fwd.sv
// Directed bench for exe_alu_fwd; expectations adapt to whether FORWARDING_EN is defined.
module tb_exe_alu_fwd;
    import exe_alu_pkg::*;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        CLK, RESET;
    logic [4:0]  RegisterA1_IN, RegisterB1_IN, WriteRegister1_IN, ShiftAmount1_IN, BypassReg1_MEMEXE;
    logic [31:0] OperandA1_IN, OperandB1_IN, MemWriteData1_IN, BypassData1_MEMEXE;
    logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN, BypassValid1_MEMEXE;
    logic [5:0]  ALU_Control1_IN;
    logic [31:0] ALU_result1_OUT, MemWriteData1_OUT, ALU_result_async1;
    logic [4:0]  WriteRegister1_OUT;
    logic        RegWrite1_OUT, MemRead1_OUT, MemWrite1_OUT, ALU_result_async_valid1;
    logic [5:0]  ALU_Control1_OUT;

    int total_cnt = 0;
    int bad_cnt   = 0;

    exe_alu_fwd dut (
        .CLK                     (CLK),
        .RESET                   (RESET),
        .RegisterA1_IN           (RegisterA1_IN),
        .OperandA1_IN            (OperandA1_IN),
        .RegisterB1_IN           (RegisterB1_IN),
        .OperandB1_IN            (OperandB1_IN),
        .WriteRegister1_IN       (WriteRegister1_IN),
        .MemWriteData1_IN        (MemWriteData1_IN),
        .RegWrite1_IN            (RegWrite1_IN),
        .MemRead1_IN             (MemRead1_IN),
        .MemWrite1_IN            (MemWrite1_IN),
        .ALU_Control1_IN         (ALU_Control1_IN),
        .ShiftAmount1_IN         (ShiftAmount1_IN),
        .BypassReg1_MEMEXE       (BypassReg1_MEMEXE),
        .BypassData1_MEMEXE      (BypassData1_MEMEXE),
        .BypassValid1_MEMEXE     (BypassValid1_MEMEXE),
        .ALU_result1_OUT         (ALU_result1_OUT),
        .WriteRegister1_OUT      (WriteRegister1_OUT),
        .MemWriteData1_OUT       (MemWriteData1_OUT),
        .RegWrite1_OUT           (RegWrite1_OUT),
        .MemRead1_OUT            (MemRead1_OUT),
        .MemWrite1_OUT           (MemWrite1_OUT),
        .ALU_Control1_OUT        (ALU_Control1_OUT),
        .ALU_result_async1       (ALU_result_async1),
        .ALU_result_async_valid1 (ALU_result_async_valid1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Async outputs only carry data when forwarding is built in.
    function automatic logic [31:0] fx(input logic [31:0] v);
        return FWD ? v : 32'd0;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_in();
        RegisterA1_IN       = 5'd1;
        OperandA1_IN        = 32'd0;
        RegisterB1_IN       = 5'd2;
        OperandB1_IN        = 32'd0;
        WriteRegister1_IN   = 5'd0;
        MemWriteData1_IN    = 32'd0;
        RegWrite1_IN        = 1'b0;
        MemRead1_IN         = 1'b0;
        MemWrite1_IN        = 1'b0;
        ALU_Control1_IN     = OP_ADD;
        ShiftAmount1_IN     = 5'd0;
        BypassReg1_MEMEXE   = 5'd0;
        BypassData1_MEMEXE  = 32'd0;
        BypassValid1_MEMEXE = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp);
        clear_in();
        ALU_Control1_IN = op;
        OperandA1_IN    = a;
        OperandB1_IN    = b;
        ShiftAmount1_IN = sh;
        #1;
        check_val({tag, "_async"}, ALU_result_async1, fx(exp));
        tick();
        check_val(tag, ALU_result1_OUT, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_res"},  ALU_result1_OUT, 32'd0);
        check_val({tag, "_wr"},   {27'd0, WriteRegister1_OUT}, 32'd0);
        check_val({tag, "_md"},   MemWriteData1_OUT, 32'd0);
        check_val({tag, "_ctl"},  {26'd0, ALU_Control1_OUT}, 32'd0);
        check_val({tag, "_flag"}, {29'd0, RegWrite1_OUT, MemRead1_OUT, MemWrite1_OUT}, 32'd0);
    endtask

    initial begin
        RESET = 1'b0;
        clear_in();
        #2;
        check_all_zero("rst");
        RESET = 1'b1;

        // Plain ADD with no forwarding hit; destination r3 with RegWrite set.
        clear_in();
        OperandA1_IN = 32'd5; OperandB1_IN = 32'd7;
        WriteRegister1_IN = 5'd3; RegWrite1_IN = 1'b1;
        #1;
        check_val("add_async", ALU_result_async1, fx(32'd12));
        check_val("add_avalid", {31'd0, ALU_result_async_valid1}, fx(32'd1));
        tick();
        check_val("add_res", ALU_result1_OUT, 32'd12);
        check_val("add_wr", {27'd0, WriteRegister1_OUT}, 32'd3);
        check_val("add_rw", {31'd0, RegWrite1_OUT}, 32'd1);

        // Own-stage result beats MEM bypass for r3.
        clear_in();
        RegisterA1_IN = 5'd3; OperandB1_IN = 32'd1; WriteRegister1_IN = 5'd5;
        BypassReg1_MEMEXE = 5'd3; BypassData1_MEMEXE = 32'd99; BypassValid1_MEMEXE = 1'b1;
        #1;
        check_val("pri1_async", ALU_result_async1, fx(32'd13));
        tick();
        check_val("pri1_res", ALU_result1_OUT, FWD ? 32'd13 : 32'd1);

        // Own result to r3 without RegWrite: MEM bypass takes over.
        clear_in();
        OperandA1_IN = 32'd5; OperandB1_IN = 32'd7; WriteRegister1_IN = 5'd3;
        tick();
        clear_in();
        RegisterA1_IN = 5'd3; OperandB1_IN = 32'd1;
        BypassReg1_MEMEXE = 5'd3; BypassData1_MEMEXE = 32'd99; BypassValid1_MEMEXE = 1'b1;
        tick();
        check_val("pri2_res", ALU_result1_OUT, FWD ? 32'd100 : 32'd1);

        // r0 is never forwarded from either source.
        clear_in();
        OperandA1_IN = 32'd55; WriteRegister1_IN = 5'd0; RegWrite1_IN = 1'b1;
        tick();
        clear_in();
        RegisterA1_IN = 5'd0; OperandB1_IN = 32'd1;
        BypassReg1_MEMEXE = 5'd0; BypassData1_MEMEXE = 32'd55; BypassValid1_MEMEXE = 1'b1;
        #1;
        check_val("r0_async", ALU_result_async1, fx(32'd1));
        tick();
        check_val("r0_res", ALU_result1_OUT, 32'd1);

        // HI/LO sequence.
        run_op("mult",     OP_MULT, 32'hFFFFFFFF, 32'd2, 5'd0, 32'd0);
        run_op("mfhi_mul", OP_MFHI, 32'd0, 32'd0, 5'd0, 32'hFFFFFFFF);
        run_op("mflo_mul", OP_MFLO, 32'd0, 32'd0, 5'd0, 32'hFFFFFFFE);
        run_op("div",      OP_DIV,  32'hFFFFFFF9, 32'd2, 5'd0, 32'd0);
        run_op("mflo_div", OP_MFLO, 32'd0, 32'd0, 5'd0, 32'hFFFFFFFD);
        run_op("mfhi_div", OP_MFHI, 32'd0, 32'd0, 5'd0, 32'hFFFFFFFF);
        run_op("div0",     OP_DIV,  32'd100, 32'd0, 5'd0, 32'd0);
        run_op("mflo_d0",  OP_MFLO, 32'd0, 32'd0, 5'd0, 32'hFFFFFFFD);
        run_op("mfhi_d0",  OP_MFHI, 32'd0, 32'd0, 5'd0, 32'hFFFFFFFF);
        run_op("multu",    OP_MULTU, 32'hFFFFFFFF, 32'd2, 5'd0, 32'd0);
        run_op("mfhi_mu",  OP_MFHI, 32'd0, 32'd0, 5'd0, 32'd1);
        run_op("divu",     OP_DIVU, 32'd17, 32'd5, 5'd0, 32'd0);
        run_op("mflo_du",  OP_MFLO, 32'd0, 32'd0, 5'd0, 32'd3);
        run_op("mthi",     OP_MTHI, 32'h0000CAFE, 32'd0, 5'd0, 32'd0);
        run_op("mfhi_mt",  OP_MFHI, 32'd0, 32'd0, 5'd0, 32'h0000CAFE);

        // Shifts, compares and misc ops.
        run_op("sra",   OP_SRA,  32'd0, 32'h80000000, 5'd4, 32'hF8000000);
        run_op("srlv",  OP_SRLV, 32'd36, 32'h000000F0, 5'd0, 32'h0000000F);
        run_op("sltu",  OP_SLTU, 32'd1, 32'hFFFFFFFF, 5'd0, 32'd1);
        run_op("slt",   OP_SLT,  32'd1, 32'hFFFFFFFF, 5'd0, 32'd0);
        run_op("sub",   OP_SUB,  32'd5, 32'd7, 5'd0, 32'hFFFFFFFE);
        run_op("nor",   OP_NOR,  32'hF0F0F0F0, 32'h0000FFFF, 5'd0, 32'h0F0F0000);
        run_op("sll",   OP_SLL,  32'd0, 32'h00000003, 5'd31, 32'h80000000);
        run_op("srav",  OP_SRAV, 32'd33, 32'h80000000, 5'd0, 32'hC0000000);
        run_op("lui",   OP_LUI,  32'd0, 32'h1234ABCD, 5'd0, 32'hABCD0000);
        run_op("passb", OP_PASSB, 32'd9, 32'h5A5A5A5A, 5'd0, 32'h5A5A5A5A);
        run_op("badop", 6'h3F,   32'd5, 32'd7, 5'd0, 32'd0);

        // Load to r4 is not a forwarding source; MEM bypass supplies the store data.
        clear_in();
        OperandA1_IN = 32'd5; OperandB1_IN = 32'd7;
        WriteRegister1_IN = 5'd4; RegWrite1_IN = 1'b1; MemRead1_IN = 1'b1;
        #1;
        check_val("ld_avalid", {31'd0, ALU_result_async_valid1}, 32'd0);
        tick();
        check_val("ld_mr", {31'd0, MemRead1_OUT}, 32'd1);
        clear_in();
        WriteRegister1_IN = 5'd4; MemWriteData1_IN = 32'h11; RegWrite1_IN = 1'b1; MemWrite1_IN = 1'b1;
        BypassReg1_MEMEXE = 5'd4; BypassData1_MEMEXE = 32'hAB; BypassValid1_MEMEXE = 1'b1;
        #1;
        check_val("st_avalid", {31'd0, ALU_result_async_valid1}, 32'd0);
        tick();
        check_val("st_md", MemWriteData1_OUT, FWD ? 32'hAB : 32'h11);
        check_val("st_mw", {31'd0, MemWrite1_OUT}, 32'd1);

        // Load outputs with non-zero values, then reset asynchronously mid-cycle.
        clear_in();
        ALU_Control1_IN = OP_PASSB; OperandB1_IN = 32'h5A; WriteRegister1_IN = 5'd9;
        MemWriteData1_IN = 32'h33; RegWrite1_IN = 1'b1; MemRead1_IN = 1'b1; MemWrite1_IN = 1'b1;
        tick();
        check_val("pre_rst_ctl", {26'd0, ALU_Control1_OUT}, {26'd0, OP_PASSB});
        #1;
        RESET = 1'b0;
        #1;
        check_all_zero("midrst");
        #1;
        RESET = 1'b1;
        run_op("mfhi_rst", OP_MFHI, 32'd0, 32'd0, 5'd0, 32'd0);
        run_op("mflo_rst", OP_MFLO, 32'd0, 32'd0, 5'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/exe_alu_fwd.md
Name: exe_alu_fwd

Overview:
- MIPS-style execute-stage core: resolves operands A, B and store data through a two-level forwarding selector, computes a 32-bit ALU result, maintains HI/LO, and registers results toward MEM.
- Sits between decode/issue and MEM.
- Also drives a combinational bypass result (plus valid) back to decode.

Parameters:
- none; all widths fixed (data 32, register index 5, control 6, shift 5).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- RegisterA1_IN  in  5  source register index of operand A.
- OperandA1_IN  in  32  operand A value from register file.
- RegisterB1_IN  in  5  source register index of operand B.
- OperandB1_IN  in  32  operand B value.
- WriteRegister1_IN  in  5  destination register index; also the store-data source index.
- MemWriteData1_IN  in  32  store data from register file.
- RegWrite1_IN  in  1  instruction writes a register.
- MemRead1_IN  in  1  load.
- MemWrite1_IN  in  1  store.
- ALU_Control1_IN  in  6  operation code.
- ShiftAmount1_IN  in  5  immediate shift amount.
- BypassReg1_MEMEXE  in  5  MEM-stage bypass register index.
- BypassData1_MEMEXE  in  32  MEM-stage bypass data.
- BypassValid1_MEMEXE  in  1  MEM-stage bypass valid.
- ALU_result1_OUT  out  32  registered ALU result.
- WriteRegister1_OUT  out  5  registered destination index.
- MemWriteData1_OUT  out  32  registered forwarded store data.
- RegWrite1_OUT, MemRead1_OUT, MemWrite1_OUT  out  1 each  registered controls.
- ALU_Control1_OUT  out  6  registered op code.
- ALU_result_async1  out  32  combinational ALU result.
- ALU_result_async_valid1  out  1  RegWrite1_IN && !(MemRead1_IN || MemWrite1_IN).

Behaviour:
- Forward selector, applied independently to A, B and store data. Read index R, register-file value D.
  - Priority 1: the stage's own output registers. Valid1 = RegWrite1_OUT && !(MemRead1_OUT || MemWrite1_OUT); if Valid1 and WriteRegister1_OUT==R, select ALU_result1_OUT.
  - Priority 2: the MEM bypass. If BypassValid1_MEMEXE and BypassReg1_MEMEXE==R, select BypassData1_MEMEXE.
  - Otherwise select D.
  - R==0 always yields D; register 0 is never forwarded.
- ALU ops, result 32-bit, arithmetic wraps, no overflow trap:
  - 00 ADD A+B; 01 SUB A-B; 02 AND; 03 OR; 04 XOR; 05 NOR.
  - 06 SLT signed A<B gives 1 else 0; 07 SLTU unsigned compare.
  - 08 SLL B<<shamt; 09 SRL logical; 0A SRA arithmetic.
  - 0B SLLV B<<A[4:0]; 0C SRLV; 0D SRAV.
  - 0E LUI {B[15:0],16'h0}; 17 PASSB gives B.
  - 0F MULT signed 64-bit A*B, {HI,LO}=product; 10 MULTU unsigned.
  - 11 DIV signed: LO=quotient, HI=remainder, truncation toward zero, remainder takes the dividend's sign; 12 DIVU unsigned.
  - 13 MFHI result=HI; 14 MFLO result=LO; 15 MTHI HI=A; 16 MTLO LO=A.
  - Any other code: result 0, HI/LO unchanged.
- Result is 0 for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- DIV/DIVU with B==0: HI/LO unchanged.
- HI/LO are registers updated at the rising edge. MFHI/MFLO read the registered value, so a MULT in cycle N is visible to an MFHI in cycle N+1.
- On every rising edge, all *_OUT registers capture their inputs or computed values; one-cycle latency; no stall or enable.
- Reset: all outputs register to 0 and HI=LO=0, asynchronously, when RESET falls. The first edge after release resumes normal capture.
- Async outputs are purely combinational and also valid during reset.

Optional Feature:
- Macro FORWARDING_EN.
- Defined: forward selectors active as above; bypass ports and async outputs functional.
- Undefined: A=OperandA1_IN, B=OperandB1_IN, store data=MemWriteData1_IN. Bypass inputs are ignored and the async outputs are driven 0; ports remain present.

Decomposition:
- Package exe_alu_pkg holds the 6-bit op-code localparams listed above and the width constants.
- One natural sub-module, fwd_sel: the two-priority forward selector, instantiated three times.
- The ALU datapath stays inline.

Test Plan:
- Reset then ADD with A=5, B=7, no forwarding: ALU_result_async1=12; after edge ALU_result1_OUT=12; assert RESET mid-run and all outputs go 0 immediately.
- Back-to-back dependency: ADD writes r3=12 (RegWrite=1); next cycle ADD reads RegisterA=3 with OperandA=0, B=1, and MEM bypass r3=99 also valid. Result=13 (priority 1 wins); with own RegWrite=0 the result is 100.
- Register 0: both forwarding sources target r0 with data 55, OperandA=0: operand stays 0.
- MULT A=0xFFFFFFFF (-1), B=2, then MFHI and MFLO: HI=0xFFFFFFFF, LO=0xFFFFFFFE. Then DIV A=-7, B=2: LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Then DIV with B=0: HI/LO unchanged.
- Shifts: SRA B=0x80000000, shamt=4 gives 0xF8000000. SRLV A=36 (uses 4), B=0xF0 gives 0x0F. SLTU A=1, B=0xFFFFFFFF gives 1; SLT with the same operands gives 0.
- Store forwarding: MemWrite=1, WriteRegister1_IN=4, MEM bypass r4=0xAB gives MemWriteData1_OUT=0xAB. A load in the prior cycle (MemRead_OUT=1) to r4 is not forwarded, and ALU_result_async_valid1=0 while the current instruction is a store.
